feed_arbiter: RTL and testbench
===============================

# feed_arbiter

Round-robin scheduler that shares the single ITCH-style byte parser between `N_FEEDS` independent market-data byte streams. It grants one feed at a time and switches feeds only at message boundaries, which it finds by tracking each message's 2-byte length header. It sits directly in front of the parser's `in_byte`/`in_valid`/`in_ready` port and tags each forwarded byte with its source feed.

## Interface

- Reset is `rst_n`, asynchronous, active-low. Clock is `clk`.

Parameters:

- `N_FEEDS`, default 4: number of input byte streams (2..16).
- `FEED_W`, default `$clog2(N_FEEDS)`: width of the feed index.

Ports:

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `s_byte`  in  `8*N_FEEDS`  feed bytes; feed i occupies `[8*i+7:8*i]`
- `s_valid`  in  `N_FEEDS`  per-feed byte valid
- `s_ready`  out  `N_FEEDS`  per-feed ready; at most one bit high
- `m_byte`  out  8  byte to parser
- `m_valid`  out  1  byte valid to parser
- `m_ready`  in  1  parser ready
- `m_feed`  out  `FEED_W`  index of currently granted feed
- `m_first`  out  1  current `m_byte` is the first (length-high) byte of a message
- `m_last`  out  1  current `m_byte` is the final byte of a message
- `len_err`  out  1  one-cycle pulse when a header length below 3 is accepted
- `busy`  out  1  high while a grant is held (any state except IDLE)

## Operation

- **Framing.** Each message begins with a 2-byte big-endian length L. L counts every byte of the message, including both length bytes. The minimum legal L is 3 (length bytes plus type).
- **FSM states.** IDLE, LEN_HI, LEN_LO, BODY.
- **IDLE.**
  - All `s_ready` are 0 and `m_valid` is 0.
  - If any `s_valid` bit is high, select the first requesting feed strictly after `last_grant`, searching upward with wrap-around.
  - Register the selection into `grant` and `last_grant`, then go to LEN_HI.
  - If no feed is requesting, stay in IDLE.
- **Pass-through (LEN_HI, LEN_LO, BODY).**
  - `m_byte = s_byte[grant]`, `m_valid = s_valid[grant]`, `s_ready[grant] = m_ready`. All other `s_ready` bits are 0.
  - These paths are combinational, with no buffering.
  - A transfer occurs when `m_valid && m_ready`.
- **LEN_HI.** On transfer, capture `len_hi`, assert `m_first` (combinational, this cycle), and go to LEN_LO.
- **LEN_LO.**
  - On transfer, form `L = {len_hi, byte}` and go to BODY.
  - If L ≥ 3, load `remain = L - 2` (16-bit).
  - If L < 3, load `remain = 1` and pulse `len_err` for one cycle; the message is forwarded as header plus one type byte.
- **BODY.**
  - Decrement `remain` on each transfer.
  - `m_last = (remain == 1)`, combinational.
  - On the transfer with `remain == 1`, go to IDLE.
- **Grant hold.** The grant is never revoked mid-message. If the granted feed's `s_valid` drops, `m_valid` drops with it, the arbiter waits indefinitely, and no other feed is served.
- **Backpressure.** When `m_ready` is low, no counter or state advances and `s_ready[grant]` is 0.
- **`m_feed`.** Holds `grant` from the cycle after the IDLE decision until the next IDLE decision.
- **L = 0xFFFF** gives `remain = 0xFFFD`. No overflow is possible because the counter is 16 bits.

## Timing

- Reset values:
  - state = IDLE, `grant` = 0, `last_grant` = `N_FEEDS-1` (so feed 0 has first priority), `remain` = 0, `len_hi` = 0.
  - Outputs: `s_ready` = 0, `m_valid` = 0, `m_feed` = 0, `m_first` = 0, `m_last` = 0, `len_err` = 0, `busy` = 0.
- Reset asserted mid-message returns to IDLE immediately. The partial message is abandoned, and the parser must be reset together with this block.
- Latency:
  - Request to first transfer is 1 cycle: the IDLE decision cycle, then LEN_HI transfers in the next cycle.
  - Last byte of one message to first byte of the next is exactly one bubble cycle (the IDLE decision cycle).
- Throughput: one byte per cycle within a message when `s_valid` and `m_ready` stay high. An L-byte message occupies L+1 cycles including the arbitration cycle.
- `len_err` is registered and asserts in the cycle after the LEN_LO transfer.
- Simultaneous requests: resolved only in IDLE by the round-robin order. A feed asserting `s_valid` mid-message is not observed until the next IDLE cycle.

## Test plan

- **Single message.** Feed 0 sends L=0x0005 bytes `00 05 41 AA BB`, with `m_ready` held at 1.
  - Five consecutive transfers with `m_feed`=0.
  - `m_first` high on `00`, `m_last` high on `BB`.
  - `busy` falls the cycle after `BB`.
- **Round-robin.** All 4 feeds hold 3-byte messages valid from reset.
  - Grant order is 0,1,2,3,0.
  - Exactly one idle cycle between messages; `s_ready` is one-hot or zero every cycle.
- **Backpressure.** Feed 2 sends an 8-byte message while `m_ready` toggles 1,0,0,1,...
  - All 8 bytes arrive in order, with no duplicates or drops.
  - `s_ready[2]` tracks `m_ready`, and `remain` freezes while `m_ready` is low.
- **Source stall.** Feed 1 drops `s_valid` for 5 cycles mid-body while feed 3 requests.
  - The grant stays on feed 1, feed 3 sees `s_ready[3]`=0 throughout, and feed 3 is served after feed 1's `m_last`.
- **Short length.** Feed 0 sends L=0x0001 followed by type `52`.
  - `len_err` pulses once, exactly 3 bytes are forwarded, and `m_last` is high on `52`.
- **Reset mid-message.** Assert `rst_n`=0 during the BODY of an L=20 message, then release.
  - All outputs return to their reset values immediately and state is IDLE.
  - Feed 0 wins the next arbitration when all feeds request.

Source files
------------

// File: rtl/feed_arbiter.sv
// Round-robin scheduler sharing one byte parser between N_FEEDS message streams.
// Grants switch only at message boundaries, found from each message's 2-byte length.
module feed_arbiter #(
    parameter int N_FEEDS = 4,
    parameter int FEED_W  = $clog2(N_FEEDS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*N_FEEDS-1:0]   s_byte,
    input  logic [N_FEEDS-1:0]     s_valid,
    output logic [N_FEEDS-1:0]     s_ready,
    output logic [7:0]             m_byte,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [FEED_W-1:0]      m_feed,
    output logic                   m_first,
    output logic                   m_last,
    output logic                   len_err,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEN_HI = 2'd1,
        LEN_LO = 2'd2,
        BODY   = 2'd3
    } state_t;

    state_t              state;
    logic [FEED_W-1:0]   grant;
    logic [FEED_W-1:0]   last_grant;
    logic [15:0]         remain;
    logic [7:0]          len_hi;

    logic [FEED_W-1:0]   pick;
    logic                found;
    logic                xfer;
    logic [15:0]         len_word;

    // Round-robin: first requester strictly above last_grant, then wrap to the low feeds.
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        for (int i = 0; i < N_FEEDS; i++) begin
            if (!found && s_valid[i] && (i > int'(last_grant))) begin
                pick  = FEED_W'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < N_FEEDS; i++) begin
            if (!found && s_valid[i] && (i <= int'(last_grant))) begin
                pick  = FEED_W'(i);
                found = 1'b1;
            end
        end
    end

    // Unbuffered pass-through from the granted feed; nothing is forwarded in IDLE.
    always_comb begin
        m_byte  = 8'h00;
        m_valid = 1'b0;
        s_ready = '0;
        if (state != IDLE) begin
            for (int i = 0; i < N_FEEDS; i++) begin
                if (grant == FEED_W'(i)) begin
                    m_byte     = s_byte[8*i +: 8];
                    m_valid    = s_valid[i];
                    s_ready[i] = m_ready;
                end
            end
        end
    end

    assign xfer     = m_valid && m_ready;
    assign len_word = {len_hi, m_byte};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= FEED_W'(N_FEEDS - 1);
            remain     <= 16'd0;
            len_hi     <= 8'd0;
            len_err    <= 1'b0;
        end else begin
            len_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant      <= pick;
                        last_grant <= pick;
                        state      <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_hi <= m_byte;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        // Short lengths still forward one type byte so the parser stays framed.
                        if (len_word >= 16'd3) begin
                            remain <= len_word - 16'd2;
                        end else begin
                            remain  <= 16'd1;
                            len_err <= 1'b1;
                        end
                        state <= BODY;
                    end
                end
                BODY: begin
                    if (xfer) begin
                        remain <= remain - 16'd1;
                        if (remain == 16'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_feed  = grant;
    assign busy    = (state != IDLE);
    assign m_first = (state == LEN_HI) && m_valid;
    assign m_last  = (state == BODY) && (remain == 16'd1);

endmodule

// File: tb/tb_feed_arbiter.sv
// Self-checking bench for feed_arbiter: per-feed source queues drive the DUT and
// a scoreboard of expected {len_err_next, feed, first, last, byte} entries checks the output.
module tb_feed_arbiter;

    localparam int N  = 4;
    localparam int FW = 2;

    logic              clk;
    logic              rst_n;
    logic [8*N-1:0]    s_byte;
    logic [N-1:0]      s_valid;
    logic [N-1:0]      s_ready;
    logic [7:0]        m_byte;
    logic              m_valid;
    logic              m_ready;
    logic [FW-1:0]     m_feed;
    logic              m_first;
    logic              m_last;
    logic              len_err;
    logic              busy;

    feed_arbiter #(.N_FEEDS(N), .FEED_W(FW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_byte  (s_byte),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_byte  (m_byte),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_feed  (m_feed),
        .m_first (m_first),
        .m_last  (m_last),
        .len_err (len_err),
        .busy    (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_xfer = 0;
    int          n_len_err = 0;
    int          mr_mode = 0;
    logic        chk_bp = 1'b0;
    logic        err_pending = 1'b0;
    logic [N-1:0] stall = '0;
    logic [N-1:0] hs = '0;
    logic [7:0]  src_q [N][$];
    logic [12:0] exp_q[$];
    int          xfer_cyc[$];
    logic [7:0]  msg_buf [64];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic fill_msg(input int len, input logic [7:0] typ);
        msg_buf[0] = 8'(len >> 8);
        msg_buf[1] = 8'(len);
        msg_buf[2] = typ;
        for (int k = 3; k < 64; k++) msg_buf[k] = 8'($urandom_range(0, 255));
    endtask

    // Queue msg_buf on a feed; a length below 3 still forwards header plus one type byte.
    task automatic queue_msg(input int feed);
        int len;
        int n;
        len = {16'd0, msg_buf[0], msg_buf[1]};
        n   = (len < 3) ? 3 : len;
        for (int k = 0; k < n; k++) begin
            src_q[feed].push_back(msg_buf[k]);
            exp_q.push_back({1'(k == 1 && len < 3), 2'(feed), 1'(k == 0), 1'(k == n - 1), msg_buf[k]});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_drain(input int budget);
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < budget) begin
            step();
            b++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        check("busy_on_last", 32'(busy), 32'd1);
        step();
        check("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int b;
        b = 0;
        while (n_xfer < target && b < budget) begin
            step();
            b++;
        end
        check("xfer_reached", 32'(n_xfer >= target), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_feed"},  32'(m_feed),  32'd0);
        check({tag, "_m_first"}, 32'(m_first), 32'd0);
        check({tag, "_m_last"},  32'(m_last),  32'd0);
        check({tag, "_len_err"}, 32'(len_err), 32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
    endtask

    // ---------------- source driver and output monitor ----------------
    initial begin
        logic [12:0] ent;
        s_valid = '0;
        s_byte  = '0;
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < N; i++)
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            #1;
            m_ready = (mr_mode == 1) ? (cyc % 3 == 0) : 1'b1;
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() > 0 && !stall[i]) begin
                    s_valid[i]       = 1'b1;
                    s_byte[8*i +: 8] = src_q[i][0];
                end else begin
                    s_valid[i]       = 1'b0;
                    s_byte[8*i +: 8] = 8'($urandom_range(0, 255));
                end
            end
            #1;
            hs = s_valid & s_ready;
            check("s_ready_onehot0", 32'($onehot0(s_ready)), 32'd1);
            if (rst_n) begin
                check("len_err", 32'(len_err), 32'(err_pending));
                if (len_err) n_len_err++;
                err_pending = 1'b0;
            end
            if (chk_bp && busy && m_feed == 2'd2)
                check("s_ready_tracks_m_ready", 32'(s_ready[2]), 32'(m_ready));
            if (m_valid && m_ready) begin
                n_xfer++;
                xfer_cyc.push_back(cyc);
                check("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    ent = exp_q.pop_front();
                    check("m_byte",  32'(m_byte),  32'(ent[7:0]));
                    check("m_last",  32'(m_last),  32'(ent[8]));
                    check("m_first", 32'(m_first), 32'(ent[9]));
                    check("m_feed",  32'(m_feed),  32'(ent[11:10]));
                    err_pending = ent[12];
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int base;
        rst_n = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");

        // Round-robin: all feeds hold 3-byte messages from reset, feed 0 has a second one.
        for (int f = 0; f < N; f++) begin
            fill_msg(3, 8'(8'h10 + f));
            queue_msg(f);
        end
        fill_msg(3, 8'h20);
        queue_msg(0);
        xfer_cyc.delete();
        step();
        rst_n = 1'b1;
        wait_drain(200);
        check("rr_count", 32'(xfer_cyc.size()), 32'd15);
        if (xfer_cyc.size() == 15)
            for (int m = 1; m < 5; m++)
                check("rr_gap", 32'(xfer_cyc[3*m] - xfer_cyc[3*m-1]), 32'd2);

        // Single message 00 05 41 AA BB from feed 0.
        fill_msg(5, 8'h41);
        msg_buf[3] = 8'hAA;
        msg_buf[4] = 8'hBB;
        xfer_cyc.delete();
        queue_msg(0);
        wait_drain(100);
        check("single_count", 32'(xfer_cyc.size()), 32'd5);
        if (xfer_cyc.size() == 5)
            check("single_span", 32'(xfer_cyc[4] - xfer_cyc[0]), 32'd4);

        // Backpressure on feed 2 with m_ready pattern 1,0,0.
        mr_mode = 1;
        chk_bp  = 1'b1;
        fill_msg(8, 8'h55);
        queue_msg(2);
        wait_drain(200);
        mr_mode = 0;
        chk_bp  = 1'b0;

        // Source stall on feed 1 mid-body while feed 3 requests.
        fill_msg(10, 8'h66);
        queue_msg(1);
        wait_xfers(n_xfer + 4, 100);
        stall[1] = 1'b1;
        fill_msg(4, 8'h77);
        queue_msg(3);
        repeat (5) begin
            step();
            check("stall_m_valid", 32'(m_valid), 32'd0);
            check("stall_s_ready3", 32'(s_ready[3]), 32'd0);
            check("stall_m_feed", 32'(m_feed), 32'd1);
        end
        stall[1] = 1'b0;
        wait_drain(200);

        // Short length: L=1 then type 52 forwards exactly three bytes.
        base = n_len_err;
        fill_msg(1, 8'h52);
        xfer_cyc.delete();
        queue_msg(0);
        wait_drain(100);
        check("short_count", 32'(xfer_cyc.size()), 32'd3);
        check("short_len_err_pulses", 32'(n_len_err - base), 32'd1);

        // Reset in the body of an L=20 message, then all feeds request.
        fill_msg(20, 8'h88);
        queue_msg(0);
        wait_xfers(n_xfer + 8, 100);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        for (int f = 0; f < N; f++) src_q[f].delete();
        exp_q.delete();
        hs = '0;
        err_pending = 1'b0;
        for (int f = 0; f < N; f++) begin
            fill_msg(3, 8'(8'h30 + f));
            queue_msg(f);
        end
        step();
        check_reset_outputs("inreset");
        rst_n = 1'b1;
        wait_drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
